// File: rtl/local_mem_arbiter_pkg.sv
// Shared types and defaults for the local memory arbiter.
package local_mem_arbiter_pkg;

    // Default number of consecutive port-1 denials before it is forced through.
    localparam int LOCAL_MEM_ARB_MAX_WAIT = 4;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        re;
    } local_mem_req_t;

endpackage

// File: rtl/local_mem_arbiter_starve.sv
// Saturating count of consecutive cycles a port-1 request has been denied.
// force_grant tells the arbiter the bound has been reached.
module lm_starve_counter
    import local_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = LOCAL_MEM_ARB_MAX_WAIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       gnt,
    output logic [3:0] cnt,
    output logic       force_grant
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    // Count denied cycles, saturate at the bound, clear on grant or withdrawn request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (req && !gnt) begin
            if (cnt != MAX_CNT) begin
                cnt <= cnt + 4'd1;
            end
        end else begin
            cnt <= 4'd0;
        end
    end

    // Bound reached: the arbiter must serve port 1 when it next can.
    always_comb begin
        force_grant = (cnt == MAX_CNT);
    end

endmodule

// File: rtl/local_mem_arbiter.sv
// Two-port arbiter for a single-port, one-cycle-latency local memory.
// Handshake: an access is accepted in any cycle where pX_req and pX_gnt are
// both high; gnt is combinational from req and registered state, and the
// requester must hold addr/be/wdata stable until it sees gnt.
// Port 0 has priority and may lock the memory for one extra cycle (AMO
// write-back); port 1 is forced through after MAX_WAIT denials.
module local_mem_arbiter
    import local_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = LOCAL_MEM_ARB_MAX_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_lock,
    input  logic        p0_re,
    input  logic [29:0] p0_addr,
    input  logic [3:0]  p0_be,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic [31:0] p0_rdata,
    output logic        p0_rvalid,
    input  logic        p1_req,
    input  logic        p1_re,
    input  logic [29:0] p1_addr,
    input  logic [3:0]  p1_be,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic [31:0] p1_rdata,
    output logic        p1_rvalid,
    output logic [29:0] mem_addr,
    output logic        mem_en,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output arb_state_t  state_dbg,
    output logic [3:0]  wait_cnt_dbg
);

    arb_state_t     state;
    arb_state_t     state_nxt;
    local_mem_req_t req0;
    local_mem_req_t req1;
    local_mem_req_t sel;
    logic [3:0]     wait_cnt;
    logic           force_p1;
    logic           owner;
    logic           rd_pend;

    assign req0 = '{addr: p0_addr, be: p0_be, wdata: p0_wdata, re: p0_re};
    assign req1 = '{addr: p1_addr, be: p1_be, wdata: p1_wdata, re: p1_re};

    lm_starve_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .req        (p1_req),
        .gnt        (p1_gnt),
        .cnt        (wait_cnt),
        .force_grant(force_p1)
    );

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision and next state; nothing is granted while in reset.
    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        state_nxt = state;
        if (!rst) begin
            case (state)
                ARB: begin
                    if (p1_req && force_p1) begin
                        p1_gnt = 1'b1;
                    end else if (p0_req) begin
                        p0_gnt = 1'b1;
                    end else if (p1_req) begin
                        p1_gnt = 1'b1;
                    end
                    if (p0_gnt && p0_lock) begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    // Lock input is ignored here so a lock spans exactly one cycle.
                    p0_gnt    = p0_req;
                    state_nxt = ARB;
                end
                default: begin
                    state_nxt = ARB;
                end
            endcase
        end
    end

    // Memory mux: granted port drives the memory; idle cycles present port 0 with no writes.
    always_comb begin
        sel       = p1_gnt ? req1 : req0;
        mem_en    = p0_gnt | p1_gnt;
        mem_addr  = sel.addr;
        mem_wdata = sel.wdata;
        mem_be    = mem_en ? sel.be : 4'd0;
    end

    // Remember which port owns the read data returning next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            owner   <= 1'b0;
        end else begin
            rd_pend <= (p0_gnt && p0_req && p0_re) || (p1_gnt && p1_req && p1_re);
            owner   <= p1_gnt;
        end
    end

    // Route read data; a reset cycle drops any response still in flight.
    always_comb begin
        p0_rdata     = mem_rdata;
        p1_rdata     = mem_rdata;
        p0_rvalid    = rd_pend && !owner && !rst;
        p1_rvalid    = rd_pend && owner && !rst;
        state_dbg    = state;
        wait_cnt_dbg = wait_cnt;
    end

endmodule

// File: tb/tb_local_mem_arbiter.sv
// Bench for local_mem_arbiter: directed scenarios plus a short random phase.
module tb_local_mem_arbiter;
  import local_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_lock, p0_re;
  logic [29:0] p0_addr;
  logic [3:0]  p0_be;
  logic [31:0] p0_wdata;
  logic        p0_gnt, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_re;
  logic [29:0] p1_addr;
  logic [3:0]  p1_be;
  logic [31:0] p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;
  logic [29:0] mem_addr;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  arb_state_t  state_dbg;
  logic [3:0]  wait_cnt_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        loaded = 1'b0;
  logic [32:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  local_mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_re(p0_re), .p0_addr(p0_addr),
    .p0_be(p0_be), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rdata(p0_rdata),
    .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_re(p1_re), .p1_addr(p1_addr), .p1_be(p1_be),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg), .wait_cnt_dbg(wait_cnt_dbg)
  );

  // memory: one-cycle read latency, read-before-write
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
      loaded <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_p0(input logic req, input logic lock, input logic re,
                        input logic [29:0] addr, input logic [3:0] be, input logic [31:0] wd);
    p0_req = req; p0_lock = lock; p0_re = re; p0_addr = addr; p0_be = be; p0_wdata = wd;
  endtask

  task automatic set_p1(input logic req, input logic re,
                        input logic [29:0] addr, input logic [3:0] be, input logic [31:0] wd);
    p1_req = req; p1_re = re; p1_addr = addr; p1_be = be; p1_wdata = wd;
  endtask

  task automatic ref_write(input logic [29:0] addr, input logic [3:0] be, input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[addr[7:0]][8*b +: 8] = wd[8*b +: 8];
  endtask

  // one cycle: inputs already set; check outputs, update scoreboard, advance
  task automatic tick(input logic eg0, input logic eg1, input string tag);
    logic [32:0] e;
    #2;
    if (rst) begin
      exp_q.delete();
      check({tag, " rst p0_rvalid"}, 64'(p0_rvalid), 64'd0);
      check({tag, " rst p1_rvalid"}, 64'(p1_rvalid), 64'd0);
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, " p0_rvalid"}, 64'(p0_rvalid), 64'(!e[32]));
      check({tag, " p1_rvalid"}, 64'(p1_rvalid), 64'(e[32]));
      check({tag, " p0_rdata"}, 64'(p0_rdata), 64'(e[31:0]));
      check({tag, " p1_rdata"}, 64'(p1_rdata), 64'(e[31:0]));
    end else begin
      check({tag, " idle p0_rvalid"}, 64'(p0_rvalid), 64'd0);
      check({tag, " idle p1_rvalid"}, 64'(p1_rvalid), 64'd0);
    end
    check({tag, " p0_gnt"}, 64'(p0_gnt), 64'(eg0));
    check({tag, " p1_gnt"}, 64'(p1_gnt), 64'(eg1));
    check({tag, " mem_en"}, 64'(mem_en), 64'(eg0 | eg1));
    if (eg1) begin
      check({tag, " mem_addr p1"}, 64'(mem_addr), 64'(p1_addr));
      check({tag, " mem_be p1"}, 64'(mem_be), 64'(p1_be));
      check({tag, " mem_wdata p1"}, 64'(mem_wdata), 64'(p1_wdata));
      if (p1_re) exp_q.push_back({1'b1, ref_mem[p1_addr[7:0]]});
      ref_write(p1_addr, p1_be, p1_wdata);
    end else if (eg0) begin
      check({tag, " mem_addr p0"}, 64'(mem_addr), 64'(p0_addr));
      check({tag, " mem_be p0"}, 64'(mem_be), 64'(p0_be));
      check({tag, " mem_wdata p0"}, 64'(mem_wdata), 64'(p0_wdata));
      if (p0_re) exp_q.push_back({1'b0, ref_mem[p0_addr[7:0]]});
      ref_write(p0_addr, p0_be, p0_wdata);
    end else begin
      check({tag, " idle mem_be"}, 64'(mem_be), 64'd0);
      check({tag, " idle mem_addr"}, 64'(mem_addr), 64'(p0_addr));
    end
    @(posedge clk);
    #1;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic locked;
    logic [3:0] wcnt;
    logic eg0, eg1;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[8'h10] = 32'hDEAD_BEEF;
    ref_mem[8'h20] = 32'h1234_5678;

    // reset with both requesting
    rst = 1'b1;
    set_p0(1, 0, 1, 30'h1, 4'h0, 32'h0);
    set_p1(1, 1, 30'h2, 4'h0, 32'h0);
    tick(0, 0, "reset0");
    tick(0, 0, "reset1");
    check("reset wait_cnt", 64'(wait_cnt_dbg), 64'd0);
    check("reset state", 64'(state_dbg), 64'(ARB));
    rst = 1'b0;
    tick(1, 0, "post_reset");

    // routing
    set_p0(1, 0, 1, 30'h10, 4'h0, 32'h0);
    set_p1(0, 0, 30'h0, 4'h0, 32'h0);
    tick(1, 0, "route_p0");
    set_p0(0, 0, 0, 30'h0, 4'h0, 32'h0);
    set_p1(1, 1, 30'h20, 4'h0, 32'h0);
    tick(0, 1, "route_p1");
    set_p1(0, 0, 30'h0, 4'h0, 32'h0);
    tick(0, 0, "route_idle");

    // lock: AMO read, write-back, port 1 waits through LOCKED
    set_p0(1, 1, 1, 30'h30, 4'h0, 32'h0);
    set_p1(1, 1, 30'h20, 4'h0, 32'h0);
    tick(1, 0, "lock_read");
    check("lock state", 64'(state_dbg), 64'(LOCKED));
    set_p0(1, 1, 0, 30'h30, 4'hF, 32'hA5A5_0001);
    tick(1, 0, "lock_wb");
    check("lock release state", 64'(state_dbg), 64'(ARB));
    set_p0(0, 0, 0, 30'h0, 4'h0, 32'h0);
    tick(0, 1, "lock_p1");
    set_p1(0, 0, 30'h0, 4'h0, 32'h0);
    set_p0(1, 0, 1, 30'h30, 4'h0, 32'h0);
    tick(1, 0, "lock_readback");
    // lock with nothing following still returns to ARB
    set_p0(1, 1, 0, 30'h31, 4'h0, 32'h0);
    tick(1, 0, "lock_empty");
    set_p0(0, 0, 0, 30'h0, 4'h0, 32'h0);
    set_p1(1, 1, 30'h21, 4'h0, 32'h0);
    tick(0, 0, "locked_idle");
    tick(0, 1, "after_empty_lock");
    set_p1(0, 0, 30'h0, 4'h0, 32'h0);
    tick(0, 0, "idle2");

    // starvation: p1 granted every fifth cycle
    for (int i = 0; i < 15; i++) begin
      set_p0(1, 0, 1, 30'(i), 4'h0, 32'h0);
      set_p1(1, 1, 30'(32 + i), 4'h0, 32'h0);
      check("starve wait_cnt", 64'(wait_cnt_dbg), 64'(i % 5));
      tick(i % 5 != 4, i % 5 == 4, "starve");
    end

    // lock lands as the bound is reached
    for (int i = 0; i < 3; i++) begin
      set_p0(1, 0, 1, 30'(50 + i), 4'h0, 32'h0);
      set_p1(1, 1, 30'h60, 4'h0, 32'h0);
      tick(1, 0, "lf_pre");
    end
    set_p0(1, 1, 1, 30'h40, 4'h0, 32'h0);
    tick(1, 0, "lf_lock");
    check("lf wait sat", 64'(wait_cnt_dbg), 64'd4);
    set_p0(1, 1, 0, 30'h40, 4'b0011, 32'hCAFE_F00D);
    tick(1, 0, "lf_locked");
    check("lf wait held", 64'(wait_cnt_dbg), 64'd4);
    set_p0(1, 0, 1, 30'h40, 4'h0, 32'h0);
    tick(0, 1, "lf_forced");
    check("lf wait clear", 64'(wait_cnt_dbg), 64'd0);
    tick(1, 0, "lf_p0_after");
    set_p0(0, 0, 0, 30'h0, 4'h0, 32'h0);
    set_p1(0, 0, 30'h0, 4'h0, 32'h0);
    tick(0, 0, "idle3");

    // reset mid-read
    set_p1(1, 1, 30'h20, 4'h0, 32'h0);
    tick(0, 1, "mr_p1_read");
    rst = 1'b1;
    set_p1(0, 0, 30'h0, 4'h0, 32'h0);
    tick(0, 0, "mr_reset");
    rst = 1'b0;
    tick(0, 0, "mr_after");
    check("mr state", 64'(state_dbg), 64'(ARB));
    check("mr wait", 64'(wait_cnt_dbg), 64'd0);
    // reset while LOCKED with a p0 read in flight and p1 waiting
    set_p0(1, 1, 1, 30'h10, 4'h0, 32'h0);
    set_p1(1, 1, 30'h20, 4'h0, 32'h0);
    tick(1, 0, "ml_lock");
    rst = 1'b1;
    tick(0, 0, "ml_reset");
    rst = 1'b0;
    set_p0(0, 0, 0, 30'h0, 4'h0, 32'h0);
    set_p1(0, 0, 30'h0, 4'h0, 32'h0);
    tick(0, 0, "ml_after");
    check("ml state", 64'(state_dbg), 64'(ARB));
    check("ml wait", 64'(wait_cnt_dbg), 64'd0);

    // random traffic against a small arbitration model
    locked = 1'b0;
    wcnt = 4'd0;
    for (int i = 0; i < 200; i++) begin
      set_p0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             30'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      set_p1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             30'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      if (locked) begin
        eg0 = p0_req;
        eg1 = 1'b0;
      end else begin
        eg1 = p1_req && (wcnt == 4'd4 || !p0_req);
        eg0 = p0_req && !eg1;
      end
      tick(eg0, eg1, "rand");
      if (locked) locked = 1'b0;
      else if (eg0 && p0_lock) locked = 1'b1;
      if (p1_req && !eg1) wcnt = (wcnt == 4'd4) ? 4'd4 : wcnt + 4'd1;
      else wcnt = 4'd0;
    end
    set_p0(0, 0, 0, 30'h0, 4'h0, 32'h0);
    set_p1(0, 0, 30'h0, 4'h0, 32'h0);
    tick(0, 0, "drain");
    check("queue empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
